axi4_slave_mem: RTL

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

---
 rtl/axi4_slave_mem_pkg.sv | 23 ++
 rtl/axi4_slave_mem_if.sv | 50 +++++
 rtl/axi4_burst_addr.sv | 34 +++
 rtl/axi4_slave_mem.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/axi4_slave_mem_pkg.sv
// Shared constants and FSM state types for the AXI4 slave memory.
package axi4_slave_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_slave_mem_if.sv
// AXI4 channel bundle between a master and the slave memory.
interface axi4_slave_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [7:0]          ARLEN;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );
endinterface

// File: rtl/axi4_burst_addr.sv
// Next word index for one burst beat; flags burst types the memory cannot honour.
module axi4_burst_addr
  import axi4_slave_mem_pkg::*;
#(
  parameter int IDX_W = 14
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       len_i,
  input  logic [1:0]       burst_i,
  output logic [IDX_W-1:0] next_idx_o,
  output logic             err_o
);
  logic [IDX_W-1:0] inc;
  logic [IDX_W-1:0] mask;
  logic             wrap_ok;

  // Bad WRAP lengths and the reserved burst code fall back to INCR.
  always_comb begin
    inc        = idx_i + IDX_W'(1);
    mask       = IDX_W'(len_i);
    wrap_ok    = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    next_idx_o = inc;
    err_o      = 1'b0;
    case (burst_i)
      BURST_FIXED: next_idx_o = idx_i;
      BURST_INCR:  next_idx_o = inc;
      BURST_WRAP: begin
        if (wrap_ok) next_idx_o = (idx_i & ~mask) | (inc & mask);
        else         err_o      = 1'b1;
      end
      default:     err_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a DEPTH x DATA_W memory; independent read and write FSMs.
//
// state   | meaning
// W_IDLE  | AWREADY high, waiting for a write address
// W_DATA  | WREADY high, accepting beats until WLAST
// W_RESP  | BVALID high, waiting for BREADY
// R_IDLE  | ARREADY high, waiting for a read address
// R_FETCH | one cycle memory read of the current beat
// R_DATA  | RVALID high, waiting for RREADY
module axi4_slave_mem
  import axi4_slave_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input logic           ACLK,
  input logic           ARESET,
  axi4_slave_mem_if.slave bus
);
  localparam int STRB_W  = DATA_W / 8;
  localparam int SH      = $clog2(STRB_W);
  localparam int IDX_W   = ADDR_W - SH;
  localparam int DEPTH_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  wr_state_t         w_state_q;
  logic [ID_W-1:0]   w_id_q;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic [7:0]        w_len_q, w_beat_q;
  logic [1:0]        w_burst_q;
  logic              w_err_q, w_burst_err, w_in_range, w_fire, w_beat_err;
  logic              awready_q, wready_q, bvalid_q;
  logic [1:0]        bresp_q;

  rd_state_t         r_state_q;
  logic [ID_W-1:0]   r_id_q;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic [7:0]        r_len_q, r_beat_q;
  logic [1:0]        r_burst_q;
  logic              r_burst_err, r_in_range;
  logic              arready_q, rvalid_q, rlast_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;

  axi4_burst_addr #(.IDX_W(IDX_W)) u_w_addr (
    .idx_i(w_idx_q), .len_i(w_len_q), .burst_i(w_burst_q),
    .next_idx_o(w_idx_d), .err_o(w_burst_err)
  );

  axi4_burst_addr #(.IDX_W(IDX_W)) u_r_addr (
    .idx_i(r_idx_q), .len_i(r_len_q), .burst_i(r_burst_q),
    .next_idx_o(r_idx_d), .err_o(r_burst_err)
  );

  assign w_in_range = (w_idx_q >> DEPTH_W) == '0;
  assign r_in_range = (r_idx_q >> DEPTH_W) == '0;
  assign w_fire     = wready_q && bus.WVALID && !ARESET;
  assign w_beat_err = !w_in_range || (bus.WLAST != (w_beat_q == w_len_q));

  // Write FSM: latch AW, accept beats, accumulate errors, return B.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= BURST_INCR;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (bus.AWVALID) begin
          w_id_q    <= bus.AWID;
          w_idx_q   <= IDX_W'(bus.AWADDR >> SH);
          w_len_q   <= bus.AWLEN;
          w_burst_q <= bus.AWBURST;
          w_beat_q  <= '0;
          w_err_q   <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          w_state_q <= W_DATA;
        end
        W_DATA: if (bus.WVALID) begin
          w_idx_q  <= w_idx_d;
          w_beat_q <= w_beat_q + 8'd1;
          w_err_q  <= w_err_q || w_beat_err;
          if (bus.WLAST) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= (w_err_q || w_beat_err || w_burst_err) ? RESP_SLVERR : RESP_OKAY;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (bus.BREADY) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled memory write; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (w_fire && w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.WSTRB[b]) mem_q[w_idx_q[DEPTH_W-1:0]][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
      end
    end
  end

  // Read FSM: fetch each beat one cycle before presenting it (read-first vs writes).
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= BURST_INCR;
    end else begin
      case (r_state_q)
        R_IDLE: if (bus.ARVALID) begin
          r_id_q    <= bus.ARID;
          r_idx_q   <= IDX_W'(bus.ARADDR >> SH);
          r_len_q   <= bus.ARLEN;
          r_burst_q <= bus.ARBURST;
          r_beat_q  <= '0;
          arready_q <= 1'b0;
          r_state_q <= R_FETCH;
        end
        R_FETCH: begin
          rdata_q   <= r_in_range ? mem_q[r_idx_q[DEPTH_W-1:0]] : '0;
          rresp_q   <= (!r_in_range || r_burst_err) ? RESP_SLVERR : RESP_OKAY;
          rlast_q   <= (r_beat_q == r_len_q);
          rvalid_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: if (bus.RREADY) begin
          rvalid_q <= 1'b0;
          if (rlast_q) begin
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end else begin
            r_beat_q  <= r_beat_q + 8'd1;
            r_idx_q   <= r_idx_d;
            r_state_q <= R_FETCH;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Handshake and response outputs read as idle for the whole reset pulse, first cycle included.
  assign bus.AWREADY = awready_q && !ARESET;
  assign bus.WREADY  = wready_q && !ARESET;
  assign bus.BVALID  = bvalid_q && !ARESET;
  assign bus.BRESP   = ARESET ? RESP_OKAY : bresp_q;
  assign bus.BID     = w_id_q;
  assign bus.ARREADY = arready_q && !ARESET;
  assign bus.RVALID  = rvalid_q && !ARESET;
  assign bus.RRESP   = ARESET ? RESP_OKAY : rresp_q;
  assign bus.RLAST   = rlast_q && !ARESET;
  assign bus.RDATA   = rdata_q;
  assign bus.RID     = r_id_q;
endmodule
